// File: rtl/wave_gen.sv
// wave_gen: single-channel oscillator (sine/square/saw/silence) on a valid/ready stream.
// Ports: clk_i, reset_i (sync, active-low), wave_sel_i[1:0], ready_i, valid_o, data_o[width_p-1:0] signed.
// Macro WAVE_GEN_SINE_EN builds the quarter-wave sine ROM; without it select 00 outputs 0.
module wave_gen #(
  parameter int  width_p         = 24,
  parameter real sampling_freq_p = 44100.0,
  parameter real note_freq_p     = 440.0
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [1:0]                wave_sel_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic signed [width_p-1:0] data_o
);

  localparam logic [1:0] SEL_SINE = 2'b00;
  localparam logic [1:0] SEL_SQR  = 2'b01;
  localparam logic [1:0] SEL_SAW  = 2'b10;

  // Phase step per sample; note_freq_p < sampling_freq_p/2 keeps it below 2^31.
  localparam real INC_R = note_freq_p * 4294967296.0 / sampling_freq_p;
  localparam logic [31:0] INC = 32'($rtoi(INC_R + 0.5));

  localparam logic signed [width_p-1:0] AMP =
    {1'b0, {(width_p-1){1'b1}}};

  logic [31:0]               phase;
  logic [31:0]               phase_next;
  logic                      accept;
  logic signed [width_p-1:0] sine_val;
  logic signed [width_p-1:0] wave;

  assign accept     = valid_o & ready_i;
  assign phase_next = accept ? phase + INC : phase;

`ifdef WAVE_GEN_SINE_EN
  localparam real HALF_PI = 1.5707963267948966;
  localparam real AMP_R   = (2.0 ** (width_p-1)) - 1.0;

  // Taylor series keeps the ROM build independent of tool math support;
  // on [0, pi/2] the truncation error is far below one LSB.
  function automatic logic [width_p-2:0] sine_entry(input int k);
    real x;
    real term;
    real acc;
    int  r;
    x    = HALF_PI * (real'(k) + 0.5) / 256.0;
    term = x;
    acc  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2*n) * (2*n+1));
      acc  = acc + term;
    end
    r = $rtoi(AMP_R * acc + 0.5);
    return (width_p-1)'(r);
  endfunction

  logic [width_p-2:0] lut [256];

  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [width_p-2:0] ENTRY = sine_entry(k);
    assign lut[k] = ENTRY;
  end

  logic [7:0]         rom_addr;
  logic [width_p-2:0] mag;
  logic [width_p-1:0] mag_ext;

  // Odd quadrants run the table backwards (255-a == ~a);
  // the upper half-cycle is the negated lower one.
  assign rom_addr = phase_next[30] ? ~phase_next[29:22]
                                   : phase_next[29:22];
  assign mag      = lut[rom_addr];
  assign mag_ext  = {1'b0, mag};
  assign sine_val = phase_next[31] ? -$signed(mag_ext)
                                   : $signed(mag_ext);
`else
  assign sine_val = '0;
`endif

  // Low phase bits only carry fractional resolution.
  logic unused_phase;
  assign unused_phase = ^phase_next;

  always_comb begin
    wave = '0;
    unique case (wave_sel_i)
      SEL_SINE: wave = sine_val;
      SEL_SQR:  wave = phase_next[31] ? -AMP : AMP;
      SEL_SAW:  wave = $signed(phase_next[31 -: width_p]);
      default:  wave = '0;
    endcase
  end

  // data_o tracks f(phase) of the phase it is stored with,
  // so a stalled sample stays put and a resume shows the next one.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      phase   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      phase   <= phase_next;
      valid_o <= 1'b1;
      data_o  <= wave;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed checks of wave_gen with default parameters.
// Covers reset, square, saw, select change, stall, mid-stream reset, sine.
module tb_wave_gen;

  localparam int          W   = 24;
  localparam logic [31:0] INC = 32'd42852281;
  localparam longint      A   = 8388607;

  logic                clk = 1'b0;
  logic                reset_i;
  logic [1:0]          wave_sel_i;
  logic                ready_i;
  logic                valid_o;
  logic signed [W-1:0] data_o;

  int vectors     = 0;
  int miscompares = 0;

  wave_gen #(
    .width_p(W),
    .sampling_freq_p(44100.0),
    .note_freq_p(440.0)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .wave_sel_i(wave_sel_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] saw(input int k);
    logic [31:0]         p;
    logic signed [W-1:0] s;
    p = 32'(k) * INC;
    s = p[31:32-W];
    return 64'(s);
  endfunction

  function automatic logic signed [63:0] ref_lut(input int k);
    real x;
    x = 3.14159265358979 * (real'(k) + 0.5) / 512.0;
    return 64'($rtoi(8388607.0 * $sin(x) + 0.5));
  endfunction

  initial begin
    reset_i    = 1'b0;
    ready_i    = 1'b1;
    wave_sel_i = 2'b01;
    tick();
    tick();
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_data", data_o, 0);

    // square: +A for samples 0..50, -A for 51..100, +A again at 101
    reset_i = 1'b1;
    tick();
    chk("sq_valid0", 64'(valid_o), 1);
    chk("sq_s0", data_o, A);
    for (int k = 1; k <= 101; k++) begin
      tick();
      chk($sformatf("sq_s%0d", k), data_o,
          (k <= 50 || k >= 101) ? A : -A);
    end

    // select change to saw with phase continuing at sample 102
    wave_sel_i = 2'b10;
    tick();
    chk("sel_saw102", data_o, saw(102));
    wave_sel_i = 2'b11;
    tick();
    chk("silence_valid", 64'(valid_o), 1);
    chk("silence_data", data_o, 0);
    wave_sel_i = 2'b10;
    tick();
    chk("sel_saw104", data_o, saw(104));

    // ready stall holds phase and data
    ready_i = 1'b0;
    tick();
    chk("stall_first", data_o, saw(104));
    for (int i = 0; i < 9; i++) tick();
    chk("stall_last", data_o, saw(104));
    chk("stall_valid", 64'(valid_o), 1);
    ready_i = 1'b1;
    tick();
    chk("resume_s105", data_o, saw(105));

    // mid-stream reset, then saw restarts at sample 0
    reset_i = 1'b0;
    tick();
    chk("mrst_valid", 64'(valid_o), 0);
    chk("mrst_data", data_o, 0);
    reset_i = 1'b1;
    tick();
    chk("saw_s0", data_o, 0);
    tick();
    chk("saw_s1", data_o, 167391);
    tick();
    chk("saw_s2", data_o, 334783);
    for (int k = 3; k <= 51; k++) tick();
    chk("saw_s51", data_o, -8240239);

`ifdef WAVE_GEN_SINE_EN
    reset_i    = 1'b0;
    wave_sel_i = 2'b00;
    tick();
    reset_i = 1'b1;
    tick();
    chk("sin_s0", data_o, 25736);
    chk("sin_s0_lut", data_o, ref_lut(0));
    for (int k = 1; k <= 25; k++) tick();
    chk("sin_s25", data_o, ref_lut(255));
    chk("sin_s25_near",
        64'((data_o > 8388554 - 64) && (data_o < 8388554 + 64)), 1);
    for (int k = 26; k <= 50; k++) tick();
    chk("sin_s50", data_o, ref_lut(1));
    tick();
    chk("sin_s51", data_o, -ref_lut(9));
    chk("sin_s51_neg", 64'(data_o < 0), 1);
`else
    reset_i    = 1'b0;
    wave_sel_i = 2'b00;
    tick();
    reset_i = 1'b1;
    tick();
    chk("nosin_valid", 64'(valid_o), 1);
    chk("nosin_s0", data_o, 0);
    for (int k = 1; k <= 25; k++) tick();
    chk("nosin_s25", data_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
